decode_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 2-to-4 active-high decoded select resource among four requesters. It picks one requester, drives the encoded select (s1,s0) and the decoded one-hot grant (d), and holds it until the holder signals completion. It sits between the requesting blocks and the decoder-controlled resource, replacing hand-driven select stimulus with a sequenced, fair controller.

---
 rtl/decode_arb_pkg.sv | 13 +
 rtl/dec2to4_en.sv | 24 ++
 rtl/decode_rr_arbiter.sv | 104 ++++++++++
 tb/tb_decode_rr_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/decode_arb_pkg.sv
// Shared constants and types for the decode round-robin arbiter.
// NUM_REQ requesters, IDX_W-bit grant index, two-state arbiter FSM.
package decode_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dec2to4_en.sv
// Combinational 2-to-4 active-high decoder with enable.
// Ports: s1,s0 select, en enable, d one-hot output (0 when en=0).
module dec2to4_en
    import decode_arb_pkg::*;
(
    input  logic               s1,
    input  logic               s0,
    input  logic               en,
    output logic [NUM_REQ-1:0] d
);

    always_comb begin
        d = '0;
        if (en) begin
            unique case ({s1, s0})
                2'b00:   d = 4'b0001;
                2'b01:   d = 4'b0010;
                2'b10:   d = 4'b0100;
                default: d = 4'b1000;
            endcase
        end
    end

endmodule

// File: rtl/decode_rr_arbiter.sv
// Round-robin arbiter driving a 2-to-4 decoded select resource.
// Ports: clk, rst_n (async low), req[3:0], done -> s1,s0, d[3:0],
// valid, timeout. Optional forced release after MAX_HOLD grant
// cycles when ARB_TIMEOUT_EN is defined; otherwise timeout is 0.
module decode_rr_arbiter
    import decode_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic               s0,
    output logic               s1,
    output logic [NUM_REQ-1:0] d,
    output logic               valid,
    output logic               timeout
);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    logic             to_hit;
    logic             rel;

    // First set request at or above ptr, wrapping modulo 4.
    // Scanning offsets from high to low leaves the nearest one.
    always_comb begin
        logic [IDX_W-1:0] cand;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) pick = cand;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    logic [CNT_W-1:0] hold_cnt;

    // hold_cnt is 0 in the first grant cycle, so reaching
    // MAX_HOLD-1 means valid has been high MAX_HOLD cycles.
    assign to_hit = (hold_cnt == CNT_W'(MAX_HOLD - 1));
`else
    assign to_hit = 1'b0;
`endif

    assign rel = done || !req[idx] || to_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            idx     <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req != '0) begin
                        state <= GRANT;
                        idx   <= pick;
                        valid <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                GRANT: begin
`ifdef ARB_TIMEOUT_EN
                    hold_cnt <= hold_cnt + 1'b1;
                    timeout  <= to_hit;
`endif
                    if (rel) begin
                        state <= IDLE;
                        valid <= 1'b0;
                        ptr   <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign s0 = idx[0];
    assign s1 = idx[1];

    dec2to4_en u_dec (
        .s1 (s1),
        .s0 (s0),
        .en (valid),
        .d  (d)
    );

endmodule

// File: tb/tb_decode_rr_arbiter.sv
// Directed self-checking bench for decode_rr_arbiter.
// Define ARB_TIMEOUT_EN to also exercise the forced-release path.
module tb_decode_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic       s0;
    logic       s1;
    logic [3:0] d;
    logic       valid;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    decode_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .s0      (s0),
        .s1      (s1),
        .d       (d),
        .valid   (valid),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] order [5];

    initial begin
        order[0] = 4'b0001;
        order[1] = 4'b0010;
        order[2] = 4'b0100;
        order[3] = 4'b1000;
        order[4] = 4'b0001;

        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 1'b0;
        #12;
        check("rst_valid", {7'd0, valid}, 8'd0);
        check("rst_d", {4'd0, d}, 8'd0);
        check("rst_sel", {6'd0, s1, s0}, 8'd0);
        check("rst_tmo", {7'd0, timeout}, 8'd0);
        step();
        check("rst_hold_valid", {7'd0, valid}, 8'd0);
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b1;

        // single requester
        @(negedge clk);
        req = 4'b0001;
        step();
        check("single_valid", {7'd0, valid}, 8'd1);
        check("single_sel", {6'd0, s1, s0}, 8'd0);
        check("single_d", {4'd0, d}, 8'h01);
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 4'b0000;
        check("single_rel_valid", {7'd0, valid}, 8'd0);
        check("single_rel_d", {4'd0, d}, 8'd0);
        check("single_rel_sel", {6'd0, s1, s0}, 8'd0);

        // fairness from ptr=0
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("fair_d%0d", i), {4'd0, d}, {4'd0, order[i]});
            done = 1'b1;
            step();
            done = 1'b0;
            check($sformatf("fair_idle%0d", i), {7'd0, valid}, 8'd0);
        end

        // pointer skip: ptr=1 now; grant 1, then req=1010
        req = 4'b0010;
        step();
        check("skip_g1", {4'd0, d}, 8'h02);
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 4'b1010;
        step();
        check("skip_g3", {4'd0, d}, 8'h08);
        check("skip_sel3", {6'd0, s1, s0}, 8'd3);
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        check("skip_g1b", {4'd0, d}, 8'h02);
        done = 1'b1;
        step();
        done = 1'b0;

        // withdrawal: ptr=2
        req = 4'b0100;
        step();
        check("wd_g2", {4'd0, d}, 8'h04);
        req = 4'b0000;
        step();
        check("wd_valid", {7'd0, valid}, 8'd0);
        check("wd_sel", {6'd0, s1, s0}, 8'd2);
        req = 4'b1111;
        step();
        check("wd_ptr3", {4'd0, d}, 8'h08);

        // no preemption on other lines
        req = 4'b1001;
        step();
        check("nopre_d", {4'd0, d}, 8'h08);
        done = 1'b1;
        req  = 4'b0000;
        step();
        check("nopre_rel", {7'd0, valid}, 8'd0);

        // done in idle ignored
        step();
        done = 1'b0;
        check("idle_done", {7'd0, valid}, 8'd0);

`ifdef ARB_TIMEOUT_EN
        do_reset();
        req = 4'b0100;
        step();
        check("to_g2", {4'd0, d}, 8'h04);
        for (int i = 1; i < 4; i++) begin
            step();
            check($sformatf("to_hold%0d", i), {7'd0, valid}, 8'd1);
            check($sformatf("to_nopulse%0d", i), {7'd0, timeout}, 8'd0);
        end
        step();
        check("to_rel", {7'd0, valid}, 8'd0);
        check("to_pulse", {7'd0, timeout}, 8'd1);
        step();
        check("to_regrant", {4'd0, d}, 8'h04);
        check("to_pulse_end", {7'd0, timeout}, 8'd0);
`else
        do_reset();
        req = 4'b0100;
        step();
        for (int i = 0; i < 20; i++) step();
        check("hold_valid", {7'd0, valid}, 8'd1);
        check("hold_d", {4'd0, d}, 8'h04);
        check("hold_tmo", {7'd0, timeout}, 8'd0);
`endif

        // async reset mid-grant, away from clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {7'd0, valid}, 8'd0);
        check("arst_d", {4'd0, d}, 8'd0);
        check("arst_sel", {6'd0, s1, s0}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1111;
        step();
        check("arst_ptr0", {4'd0, d}, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
